// File: rtl/soc_mem_pkg.sv
// Shared types and default widths for the program/data memory arbiter.
package soc_mem_pkg;

   localparam int AW_DEF = 12;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE_A = 2'd1,
      ISSUE_B = 2'd2,
      WAIT    = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/memio_arbiter.sv
// Two-requester arbiter for the single-port program/data memory.
// Requester A is the CPU (may lock the memory for one follow-up access
// to keep read-modify-write pairs atomic). Requester B is the SPI loader.
// One access is in flight at a time. mem_rdata is sampled on the
// MEM_LAT-th rising edge after the edge that launches a read mem_en,
// and is presented registered on the requester's rdata with rvalid.
module memio_arbiter
   import soc_mem_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          a_lock,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [2:0] LAT3 = 3'(MEM_LAT);

   arb_state_t state;
   req_id_t    last_served;
   req_id_t    cur_id;
   logic       lock;
   logic [2:0] lat_cnt;
   logic       pick_a;
   logic       pick_b;
   logic       capture;

   // Arbitration: a held lock gives A priority, otherwise round-robin on ties.
   always_comb begin
      pick_a = 1'b0;
      pick_b = 1'b0;
      if (lock && a_req) begin
         pick_a = 1'b1;
      end else if (a_req && b_req) begin
         if (last_served == REQ_B) pick_a = 1'b1;
         else                      pick_b = 1'b1;
      end else if (a_req) begin
         pick_a = 1'b1;
      end else if (b_req) begin
         pick_b = 1'b1;
      end
   end

   // Read data is captured on the MEM_LAT-th edge after launch; with
   // MEM_LAT=1 that is the edge closing the ISSUE cycle itself.
   always_comb begin
      capture = 1'b0;
      if ((state == ISSUE_A || state == ISSUE_B) && !mem_we && LAT3 == 3'd1)
         capture = 1'b1;
      else if (state == WAIT && !a_rvalid && !b_rvalid && (lat_cnt + 3'd1) == LAT3)
         capture = 1'b1;
   end

   // Control FSM and registered memory command port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= REQ_B;
         cur_id      <= REQ_A;
         lock        <= 1'b0;
         lat_cnt     <= 3'd0;
         a_gnt       <= 1'b0;
         b_gnt       <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE: begin
               lat_cnt <= 3'd0;
               // A lock whose owner has gone quiet is abandoned so B is not starved.
               if (lock && !a_req) lock <= 1'b0;
               if (pick_a) begin
                  state       <= ISSUE_A;
                  cur_id      <= REQ_A;
                  last_served <= REQ_A;
                  // The locked access itself cannot re-lock: B waits at most two A accesses.
                  lock        <= a_lock & ~lock;
                  a_gnt       <= 1'b1;
                  mem_en      <= 1'b1;
                  mem_we      <= a_we;
                  mem_addr    <= a_addr;
                  mem_wdata   <= a_wdata;
               end else if (pick_b) begin
                  state       <= ISSUE_B;
                  cur_id      <= REQ_B;
                  last_served <= REQ_B;
                  b_gnt       <= 1'b1;
                  mem_en      <= 1'b1;
                  mem_we      <= b_we;
                  mem_addr    <= b_addr;
                  mem_wdata   <= b_wdata;
               end
            end
            ISSUE_A, ISSUE_B: begin
               if (mem_we) begin
                  state <= IDLE;
               end else begin
                  state   <= WAIT;
                  lat_cnt <= 3'd1;
               end
            end
            WAIT: begin
               if (a_rvalid || b_rvalid) begin
                  state   <= IDLE;
                  lat_cnt <= 3'd0;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read return path: one-cycle rvalid pulse, rdata held until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= capture && (cur_id == REQ_A);
         b_rvalid <= capture && (cur_id == REQ_B);
         if (capture && cur_id == REQ_A) a_rdata <= mem_rdata;
         if (capture && cur_id == REQ_B) b_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_memio_arbiter.sv
// Directed bench for memio_arbiter: a MEM_LAT=1 instance driven from a
// cycle table, and a MEM_LAT=3 instance exercised by hand-written sequences.
module tb_memio_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 0, a_we = 0, a_lock = 0;
   logic [11:0] a_addr = '0;
   logic [15:0] a_wdata = '0;
   logic        b_req = 0, b_we = 0;
   logic [11:0] b_addr = '0;
   logic [15:0] b_wdata = '0;

   logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_en1, mem_we1;
   logic [15:0] a_rdata1, b_rdata1, mem_wdata1, mem_rdata1;
   logic [11:0] mem_addr1;
   logic        a_gnt3, a_rvalid3, b_gnt3, b_rvalid3, mem_en3, mem_we3;
   logic [15:0] a_rdata3, b_rdata3, mem_wdata3, mem_rdata3;
   logic [11:0] mem_addr3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memio_arbiter #(.AW(12), .DW(16), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
      .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1)
   );

   memio_arbiter #(.AW(12), .DW(16), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
      .a_gnt(a_gnt3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3)
   );

   // Memory contents seen by reads.
   function automatic logic [15:0] mem_val(input logic [11:0] a);
      case (a)
         12'h010: mem_val = 16'h7A5C;
         12'h020: mem_val = 16'h1357;
         12'h030: mem_val = 16'h2468;
         default: mem_val = {4'hD, a};
      endcase
   endfunction

   // Latency-1 memory: data valid during the command cycle, sampled on its closing edge.
   always_comb mem_rdata1 = (mem_en1 && !mem_we1) ? mem_val(mem_addr1) : 16'hDEAD;

   // Latency-3 memory: data valid only in the cycle before the third edge after launch.
   logic [3:0]  pc3 = '0;
   logic [11:0] pa3 = '0;
   always @(posedge clk) begin
      if (mem_en3 && !mem_we3) begin
         pa3 <= mem_addr3;
         pc3 <= 4'd1;
      end else if (pc3 != 4'd0 && pc3 != 4'd15) begin
         pc3 <= pc3 + 4'd1;
      end
   end
   always_comb mem_rdata3 = (pc3 == 4'd2) ? mem_val(pa3) : 16'hDEAD;

   typedef struct {
      logic        ar, aw;
      logic [11:0] aa;
      logic [15:0] ad;
      logic        al, br, bw;
      logic [11:0] ba;
      logic [15:0] bd;
      logic        eag, ebg, een, ewe;
      logic [11:0] eaddr;
      logic [15:0] ewd;
      logic        earv, ebrv;
      logic [15:0] erd;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int ar, aw, aa, ad, al, br, bw, ba, bd,
                               input int eag, ebg, een, ewe, eaddr, ewd, earv, ebrv, erd);
      vec_t v;
      v.ar = ar[0];  v.aw = aw[0];  v.aa = aa[11:0]; v.ad = ad[15:0]; v.al = al[0];
      v.br = br[0];  v.bw = bw[0];  v.ba = ba[11:0]; v.bd = bd[15:0];
      v.eag = eag[0]; v.ebg = ebg[0]; v.een = een[0]; v.ewe = ewe[0];
      v.eaddr = eaddr[11:0]; v.ewd = ewd[15:0];
      v.earv = earv[0]; v.ebrv = ebrv[0]; v.erd = erd[15:0];
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag, input logic ag, bg, arv, brv,
                           input logic [15:0] ard, brd, input logic en, we,
                           input logic [11:0] addr, input logic [15:0] wd);
      check({tag, ".a_gnt"},     32'(ag),   0);
      check({tag, ".b_gnt"},     32'(bg),   0);
      check({tag, ".a_rvalid"},  32'(arv),  0);
      check({tag, ".b_rvalid"},  32'(brv),  0);
      check({tag, ".a_rdata"},   32'(ard),  0);
      check({tag, ".b_rdata"},   32'(brd),  0);
      check({tag, ".mem_en"},    32'(en),   0);
      check({tag, ".mem_we"},    32'(we),   0);
      check({tag, ".mem_addr"},  32'(addr), 0);
      check({tag, ".mem_wdata"}, 32'(wd),   0);
   endtask

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_ard;
      logic [15:0] exp_brd;
      exp_ard = '0;
      exp_brd = '0;

      // Round robin, both writing continuously; first tie after reset goes to A.
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      add(1,1,'h100,'hA000,0, 1,1,'h200,'hB000,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h100,'hA000,0, 1,1,'h200,'hB000,    1,0,1,1,'h100,'hA000,0,0,0);
      add(1,1,'h101,'hA001,0, 1,1,'h200,'hB000,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h101,'hA001,0, 1,1,'h200,'hB000,    0,1,1,1,'h200,'hB000,0,0,0);
      add(1,1,'h101,'hA001,0, 1,1,'h201,'hB001,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h101,'hA001,0, 1,1,'h201,'hB001,    1,0,1,1,'h101,'hA001,0,0,0);
      add(1,1,'h102,'hA002,0, 1,1,'h201,'hB001,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h102,'hA002,0, 1,1,'h201,'hB001,    0,1,1,1,'h201,'hB001,0,0,0);
      add(1,1,'h102,'hA002,0, 1,1,'h202,'hB002,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h102,'hA002,0, 1,1,'h202,'hB002,    1,0,1,1,'h102,'hA002,0,0,0);
      add(1,1,'h103,'hA003,0, 1,1,'h202,'hB002,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h103,'hA003,0, 1,1,'h202,'hB002,    0,1,1,1,'h202,'hB002,0,0,0);
      add(1,1,'h103,'hA003,0, 1,1,'h203,'hB003,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h103,'hA003,0, 1,1,'h203,'hB003,    1,0,1,1,'h103,'hA003,0,0,0);
      add(0,0,0,0,0, 1,1,'h203,'hB003,             0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 1,1,'h203,'hB003,             0,1,1,1,'h203,'hB003,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // A read of 0x010 alone.
      add(1,0,'h010,0,0, 0,0,0,0,                  0,0,0,0,0,0,0,0,0);
      add(1,0,'h010,0,0, 0,0,0,0,                  1,0,1,0,'h010,0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,1,0,'h7A5C);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // B write 0xFFF <= 0x1234.
      add(0,0,0,0,0, 1,1,'hFFF,'h1234,             0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 1,1,'hFFF,'h1234,             0,1,1,1,'hFFF,'h1234,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // Locked read-modify-write by A with B requesting throughout.
      add(1,0,'h020,0,1, 1,0,'h030,0,              0,0,0,0,0,0,0,0,0);
      add(1,0,'h020,0,1, 1,0,'h030,0,              1,0,1,0,'h020,0,0,0,0);
      add(1,1,'h020,'h5555,0, 1,0,'h030,0,         0,0,0,0,0,0,1,0,'h1357);
      add(1,1,'h020,'h5555,0, 1,0,'h030,0,         0,0,0,0,0,0,0,0,0);
      add(1,1,'h020,'h5555,0, 1,0,'h030,0,         1,0,1,1,'h020,'h5555,0,0,0);
      add(0,0,0,0,0, 1,0,'h030,0,                  0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 1,0,'h030,0,                  0,1,1,0,'h030,0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,1,'h2468);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // Lock has cleared: after an A access a tie goes to B.
      add(1,0,'h010,0,0, 0,0,0,0,                  0,0,0,0,0,0,0,0,0);
      add(1,0,'h010,0,0, 0,0,0,0,                  1,0,1,0,'h010,0,0,0,0);
      add(1,1,'h040,'h0F0F,0, 1,1,'h050,'h00FF,    0,0,0,0,0,0,1,0,'h7A5C);
      add(1,1,'h040,'h0F0F,0, 1,1,'h050,'h00FF,    0,0,0,0,0,0,0,0,0);
      add(1,1,'h040,'h0F0F,0, 1,1,'h050,'h00FF,    0,1,1,1,'h050,'h00FF,0,0,0);
      add(1,1,'h040,'h0F0F,0, 0,0,0,0,             0,0,0,0,0,0,0,0,0);
      add(1,1,'h040,'h0F0F,0, 0,0,0,0,             1,0,1,1,'h040,'h0F0F,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // B request raised and withdrawn while busy: nothing issued for B.
      add(1,1,'h060,'h6060,0, 0,0,0,0,             0,0,0,0,0,0,0,0,0);
      add(1,1,'h060,'h6060,0, 1,0,'h030,0,         1,0,1,1,'h060,'h6060,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);
      // Lock taken, A then goes quiet: lock dropped and B served.
      add(1,0,'h010,0,1, 0,0,0,0,                  0,0,0,0,0,0,0,0,0);
      add(1,0,'h010,0,1, 0,0,0,0,                  1,0,1,0,'h010,0,0,0,0);
      add(0,0,0,0,0, 1,0,'h030,0,                  0,0,0,0,0,0,1,0,'h7A5C);
      add(0,0,0,0,0, 1,0,'h030,0,                  0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0, 1,0,'h030,0,                  0,1,1,0,'h030,0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,1,'h2468);
      add(0,0,0,0,0, 0,0,0,0,                      0,0,0,0,0,0,0,0,0);

      // Reset state of both instances.
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset1", a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, a_rdata1, b_rdata1,
               mem_en1, mem_we1, mem_addr1, mem_wdata1);
      chk_zero("reset3", a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, a_rdata3, b_rdata3,
               mem_en3, mem_we3, mem_addr3, mem_wdata3);
      rst = 1'b0;

      // Table against the MEM_LAT=1 instance.
      for (int i = 0; i < vecs.size(); i++) begin
         string t;
         @(posedge clk);
         #1;
         a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa;
         a_wdata = vecs[i].ad; a_lock = vecs[i].al;
         b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
         @(negedge clk);
         if (vecs[i].earv) exp_ard = vecs[i].erd;
         if (vecs[i].ebrv) exp_brd = vecs[i].erd;
         t = $sformatf("v%0d", i);
         check({t, ".a_gnt"},     32'(a_gnt1),     32'(vecs[i].eag));
         check({t, ".b_gnt"},     32'(b_gnt1),     32'(vecs[i].ebg));
         check({t, ".mem_en"},    32'(mem_en1),    32'(vecs[i].een));
         check({t, ".mem_we"},    32'(mem_we1),    32'(vecs[i].ewe));
         check({t, ".mem_addr"},  32'(mem_addr1),  32'(vecs[i].eaddr));
         check({t, ".mem_wdata"}, 32'(mem_wdata1), 32'(vecs[i].ewd));
         check({t, ".a_rvalid"},  32'(a_rvalid1),  32'(vecs[i].earv));
         check({t, ".b_rvalid"},  32'(b_rvalid1),  32'(vecs[i].ebrv));
         check({t, ".a_rdata"},   32'(a_rdata1),   32'(exp_ard));
         check({t, ".b_rdata"},   32'(b_rdata1),   32'(exp_brd));
      end

      // Asynchronous reset clears held read data immediately.
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk_zero("rst_mid3", a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, a_rdata3, b_rdata3,
               mem_en3, mem_we3, mem_addr3, mem_wdata3);
      @(negedge clk);
      rst = 1'b0;

      // MEM_LAT=3 read by B; A requesting during WAIT is held off.
      @(posedge clk); #1;
      b_req = 1; b_we = 0; b_addr = 12'h030;
      @(posedge clk); #1;
      b_req = 0; a_req = 1; a_we = 1; a_addr = 12'h070; a_wdata = 16'h7070;
      @(negedge clk);
      check("l3.b_gnt",    32'(b_gnt3),    1);
      check("l3.mem_en",   32'(mem_en3),   1);
      check("l3.mem_we",   32'(mem_we3),   0);
      check("l3.mem_addr", 32'(mem_addr3), 32'h030);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check($sformatf("l3.b_rvalid+%0d", k), 32'(b_rvalid3), (k == 3) ? 1 : 0);
         check($sformatf("l3.mem_en+%0d", k),   32'(mem_en3),   0);
         check($sformatf("l3.a_gnt+%0d", k),    32'(a_gnt3),    0);
      end
      check("l3.b_rdata", 32'(b_rdata3), 32'h2468);
      @(negedge clk);
      check("l3.idle_a_gnt",    32'(a_gnt3),    0);
      check("l3.idle_b_rvalid", 32'(b_rvalid3), 0);
      @(negedge clk);
      check("l3.next_a_gnt",  32'(a_gnt3),     1);
      check("l3.next_we",     32'(mem_we3),    1);
      check("l3.next_addr",   32'(mem_addr3),  32'h070);
      check("l3.next_wdata",  32'(mem_wdata3), 32'h7070);
      idle_inputs();
      @(negedge clk);

      // Reset during WAIT of an A read: read dropped, first tie afterwards to A.
      @(posedge clk); #1;
      a_req = 1; a_we = 0; a_addr = 12'h010;
      @(posedge clk); #1;
      a_req = 0;
      @(negedge clk);
      check("rw.a_gnt", 32'(a_gnt3), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk_zero("rw.async", a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, a_rdata3, b_rdata3,
               mem_en3, mem_we3, mem_addr3, mem_wdata3);
      a_req = 1; a_we = 0; a_addr = 12'h010;
      b_req = 1; b_we = 0; b_addr = 12'h030;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rw.no_rvalid%0d", k), 32'(a_rvalid3), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("rw.tie_a_gnt",   32'(a_gnt3),    1);
      check("rw.tie_b_gnt",   32'(b_gnt3),    0);
      check("rw.tie_addr",    32'(mem_addr3), 32'h010);
      check("rw.tie_rvalid",  32'(a_rvalid3), 0);
      a_req = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check($sformatf("rw.a_rvalid+%0d", k), 32'(a_rvalid3), (k == 3) ? 1 : 0);
      end
      check("rw.a_rdata", 32'(a_rdata3), 32'h7A5C);
      idle_inputs();
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
